// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Register-address width, zero register, default data width, select codes.
package wb_arbiter_pkg;

  localparam int REG_AW    = 5;
  localparam int WIDTH_DEF = 32;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PIPE,
    SEL_LU
  } sel_e;

  function automatic logic is_live(input logic [REG_AW-1:0] r);
    return r != ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO (power-of-2 depth, show-ahead head).
// Ports: clk, reset, push/din, pop/dout, full, empty, count.
module wb_fifo #(
  parameter int DW    = 37,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [CW-1:0] CMAX = CW'(DEPTH);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [AW-1:0] AONE = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = count == CMAX;
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is allowed only when the head leaves
  // in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CONE;
        2'b01:   count <= count - CONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline and long-latency results onto one
// regfile write port, tracks busy registers for decode hazards.
// Ports: clk, reset, pipe_*, lu_* (valid/ready), issue_*, rreg1/2,
//        hazard1/2, pipe_throttle, regwrite/wreg/wdata.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int NREG       = 32,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_regwrite,
  input  logic [REG_AW-1:0] pipe_wreg,
  input  logic [WIDTH-1:0]  pipe_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_wreg,
  input  logic [WIDTH-1:0]  lu_wdata,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_wreg,
  input  logic [REG_AW-1:0] rreg1,
  input  logic [REG_AW-1:0] rreg2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              pipe_throttle,
  output logic              regwrite,
  output logic [REG_AW-1:0] wreg,
  output logic [WIDTH-1:0]  wdata
);

  localparam int EW = WIDTH + REG_AW;
  localparam int QCW = $clog2(QDEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);

  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [SW-1:0] SONE = SW'(1);
  localparam logic [QCW-1:0] QMAX = QCW'(QDEPTH);

  logic              pipe_win;
  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [QCW-1:0]    q_count;
  logic [EW-1:0]     q_head;
  logic [REG_AW-1:0] head_wreg;
  logic [WIDTH-1:0]  head_wdata;
  sel_e              sel;
  logic              src_lu;
  logic [SW-1:0]     starve;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              lu_commit;

  // Register 0 is never written, so such writes do not claim the port.
  assign pipe_win = pipe_regwrite && is_live(pipe_wreg);

  assign lu_ready = !q_full;
  assign q_push   = lu_valid && lu_ready && is_live(lu_wreg);
  assign q_pop    = sel == SEL_LU;

  wb_fifo #(
    .DW   (EW),
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (q_push),
    .pop  (q_pop),
    .din  ({lu_wreg, lu_wdata}),
    .dout (q_head),
    .full (q_full),
    .empty(q_empty),
    .count(q_count)
  );

  assign head_wreg  = q_head[WIDTH +: REG_AW];
  assign head_wdata = q_head[WIDTH-1:0];

  // The pipeline cannot stall, so it always wins the port.
  always_comb begin
    sel = SEL_NONE;
    if (pipe_win) begin
      sel = SEL_PIPE;
    end else if (!q_empty) begin
      sel = SEL_LU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite <= 1'b0;
      wreg     <= '0;
      wdata    <= '0;
      src_lu   <= 1'b0;
    end else begin
      unique case (sel)
        SEL_PIPE: begin
          regwrite <= 1'b1;
          wreg     <= pipe_wreg;
          wdata    <= pipe_wdata;
          src_lu   <= 1'b0;
        end
        SEL_LU: begin
          regwrite <= 1'b1;
          wreg     <= head_wreg;
          wdata    <= head_wdata;
          src_lu   <= 1'b1;
        end
        default: begin
          regwrite <= 1'b0;
          src_lu   <= 1'b0;
        end
      endcase
    end
  end

  // Saturation also covers an upstream that ignores the throttle:
  // the pipeline keeps winning and the count simply holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve <= '0;
    end else if (q_empty || q_pop) begin
      starve <= '0;
    end else if (pipe_win && starve != SMAX) begin
      starve <= starve + SONE;
    end
  end

  assign pipe_throttle = starve == SMAX;

  // The clear lands on the same edge the regfile commits the value,
  // so decode never needs a bypass from this stage.
  assign lu_commit = regwrite && src_lu;

  always_comb begin
    busy_nxt = busy;
    if (lu_commit) begin
      busy_nxt[wreg] = 1'b0;
    end
    if (issue_valid && is_live(issue_wreg)) begin
      busy_nxt[issue_wreg] = 1'b1;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign hazard1 = busy[rreg1];
  assign hazard2 = busy[rreg2];

`ifndef SYNTHESIS
  logic clr_same;

  assign clr_same = lu_commit && wreg == issue_wreg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (issue_valid && is_live(issue_wreg)) begin
        assert (!busy[issue_wreg] || clr_same)
          else $error("wb_arbiter: issue to busy r%0d", issue_wreg);
      end
      if (pipe_win) begin
        assert (!busy[pipe_wreg])
          else $error("wb_arbiter: WAW on busy r%0d", pipe_wreg);
      end
      assert (q_count <= QMAX)
        else $error("wb_arbiter: fifo count %0d", q_count);
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus
// hand-written multi-cycle sequences.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_regwrite;
  logic [4:0]  pipe_wreg;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wreg;
  logic [31:0] lu_wdata;
  logic        issue_valid;
  logic [4:0]  issue_wreg;
  logic [4:0]  rreg1;
  logic [4:0]  rreg2;
  logic        hazard1;
  logic        hazard2;
  logic        pipe_throttle;
  logic        regwrite;
  logic [4:0]  wreg;
  logic [31:0] wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_regwrite(pipe_regwrite),
    .pipe_wreg    (pipe_wreg),
    .pipe_wdata   (pipe_wdata),
    .lu_valid     (lu_valid),
    .lu_ready     (lu_ready),
    .lu_wreg      (lu_wreg),
    .lu_wdata     (lu_wdata),
    .issue_valid  (issue_valid),
    .issue_wreg   (issue_wreg),
    .rreg1        (rreg1),
    .rreg2        (rreg2),
    .hazard1      (hazard1),
    .hazard2      (hazard2),
    .pipe_throttle(pipe_throttle),
    .regwrite     (regwrite),
    .wreg         (wreg),
    .wdata        (wdata)
  );

  typedef struct {
    logic        rst;
    logic        pw;
    logic [4:0]  pr;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_rw;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic        e_rdy;
    logic        e_h1;
    logic        e_h2;
    logic        e_thr;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic pw, input logic [4:0] pr,
                        input logic [31:0] pd, input logic lv,
                        input logic [4:0] lr, input logic [31:0] ld,
                        input logic iv, input logic [4:0] ir);
    pipe_regwrite = pw;
    pipe_wreg     = pr;
    pipe_wdata    = pd;
    lu_valid      = lv;
    lu_wreg       = lr;
    lu_wdata      = ld;
    issue_valid   = iv;
    issue_wreg    = ir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic chk_wr(input string nm, input logic rw,
                        input logic [4:0] r, input logic [31:0] d);
    chk({nm, "_rw"}, 32'(regwrite), 32'(rw));
    chk({nm, "_wreg"}, 32'(wreg), 32'(r));
    chk({nm, "_wdata"}, wdata, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    logic acc;
    logic [4:0] src_r [3];
    logic [31:0] src_d [3];

    // rst pw pr pd lv lr ld iv ir r1 r2 | rw wreg wdata rdy h1 h2 thr
    tbl[0]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd0, 5'd0,
                1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b1, 5'd5, 5'd5, 5'd6,
                1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF,
                1'b0, 5'd0, 5'd5, 5'd6,
                1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd5, 5'd6,
                1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd5, 5'd6,
                1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22,
                1'b0, 5'd0, 5'd0, 5'd0,
                1'b1, 5'd3, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd0, 5'd0,
                1'b1, 5'd7, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd0, 5'd0,
                1'b0, 5'd7, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99,
                1'b0, 5'd0, 5'd0, 5'd0,
                1'b0, 5'd7, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd0, 5'd0,
                1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hAA,
                1'b0, 5'd0, 5'd0, 5'd0,
                1'b0, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd0, 5'd0,
                1'b0, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    rreg1 = 5'd0;
    rreg2 = 5'd0;
    idle();

    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst;
      rreg1 = tbl[i].r1;
      rreg2 = tbl[i].r2;
      set_in(tbl[i].pw, tbl[i].pr, tbl[i].pd, tbl[i].lv,
             tbl[i].lr, tbl[i].ld, tbl[i].iv, tbl[i].ir);
      tick();
      chk($sformatf("v%0d_rw", i), 32'(regwrite), 32'(tbl[i].e_rw));
      chk($sformatf("v%0d_wreg", i), 32'(wreg), 32'(tbl[i].e_wreg));
      chk($sformatf("v%0d_wdata", i), wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_ready", i), 32'(lu_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_h1", i), 32'(hazard1), 32'(tbl[i].e_h1));
      chk($sformatf("v%0d_h2", i), 32'(hazard2), 32'(tbl[i].e_h2));
      chk($sformatf("v%0d_thr", i), 32'(pipe_throttle),
          32'(tbl[i].e_thr));
    end

    // Backpressure: pipe busy for 4 cycles, three queued results.
    src_r = '{5'd10, 5'd11, 5'd12};
    src_d = '{32'hA0, 32'hA1, 32'hA2};
    sent = 0;
    got = 0;
    for (int c = 0; c < 16; c++) begin
      set_in(c < 4, 5'd1, 32'h100 + 32'(c),
             sent < 3, (sent < 3) ? src_r[sent] : 5'd0,
             (sent < 3) ? src_d[sent] : 32'h0, 1'b0, 5'd0);
      #3;
      if (c >= 2 && c <= 4) begin
        chk($sformatf("bp_ready_c%0d", c), 32'(lu_ready), 32'd0);
      end
      acc = lu_valid && lu_ready;
      tick();
      if (acc) sent++;
      if (c < 4) begin
        chk_wr($sformatf("bp_pipe_c%0d", c), 1'b1, 5'd1,
               32'h100 + 32'(c));
      end else if (regwrite) begin
        if (got < 3) begin
          chk($sformatf("bp_order%0d_wreg", got), 32'(wreg),
              32'(src_r[got]));
          chk($sformatf("bp_order%0d_wdata", got), wdata, src_d[got]);
        end
        got++;
      end
    end
    chk("bp_sent", 32'(sent), 32'd3);
    chk("bp_written", 32'(got), 32'd3);

    // Starvation and throttle violation.
    set_in(1'b1, 5'd2, 32'h200, 1'b1, 5'd20, 32'h20, 1'b0, 5'd0);
    tick();
    chk("st_thr_c0", 32'(pipe_throttle), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b1, 5'd2, 32'h200 + 32'(k), 1'b0, 5'd0, 32'h0,
             1'b0, 5'd0);
      tick();
      chk($sformatf("st_thr_c%0d", k), 32'(pipe_throttle),
          32'(k == 4));
      chk_wr($sformatf("st_pipe_c%0d", k), 1'b1, 5'd2,
             32'h200 + 32'(k));
    end
    set_in(1'b1, 5'd2, 32'h2FF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    chk("st_thr_hold", 32'(pipe_throttle), 32'd1);
    chk_wr("st_violate", 1'b1, 5'd2, 32'h2FF);
    idle();
    tick();
    chk("st_thr_clear", 32'(pipe_throttle), 32'd0);
    chk_wr("st_drain", 1'b1, 5'd20, 32'h20);
    tick();
    chk("st_empty_rw", 32'(regwrite), 32'd0);

    // Set/clear collision on register 4.
    rreg1 = 5'd4;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    tick();
    chk("col_set", 32'(hazard1), 32'd1);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    tick();
    chk("col_queued", 32'(hazard1), 32'd1);
    idle();
    tick();
    chk_wr("col_out", 1'b1, 5'd4, 32'h44);
    chk("col_pre", 32'(hazard1), 32'd1);
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    tick();
    chk("col_setwins", 32'(hazard1), 32'd1);
    idle();
    tick();
    chk("col_hold", 32'(hazard1), 32'd1);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h45, 1'b0, 5'd0);
    tick();
    idle();
    tick();
    chk_wr("col_out2", 1'b1, 5'd4, 32'h45);
    tick();
    chk("col_clear", 32'(hazard1), 32'd0);

    // Reset mid-operation drops queued results and busy bits.
    rreg2 = 5'd8;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8);
    tick();
    chk("rs_busy", 32'(hazard2), 32'd1);
    set_in(1'b1, 5'd1, 32'h301, 1'b1, 5'd13, 32'h13, 1'b0, 5'd0);
    tick();
    set_in(1'b1, 5'd1, 32'h302, 1'b1, 5'd14, 32'h14, 1'b0, 5'd0);
    tick();
    chk("rs_full", 32'(lu_ready), 32'd0);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_wr("rs_out", 1'b0, 5'd0, 32'h0);
    chk("rs_ready", 32'(lu_ready), 32'd1);
    chk("rs_h2", 32'(hazard2), 32'd0);
    chk("rs_thr", 32'(pipe_throttle), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rs_nowrite%0d", k), 32'(regwrite), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file. Merges two result sources onto the regfile's single write port:
  - the in-order pipeline writeback, which cannot stall;
  - a long-latency unit (mul/div, cache-miss loads), using a valid/ready handshake.
- Long-latency results are buffered in a small FIFO.
- A per-register busy scoreboard tells decode when a source register is still waiting for a long-latency result.

Parameters:
- WIDTH, 32, data width.
- NREG, 32, number of architectural registers.
- QDEPTH, 2, long-latency result FIFO depth (power of 2, >=2).
- STARVE_MAX, 4, max cycles a queued result may wait before the pipeline is throttled.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pipe_regwrite  in  1  pipeline result valid
- pipe_wreg  in  5  pipeline destination register
- pipe_wdata  in  WIDTH  pipeline result
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept a result
- lu_wreg  in  5  long-latency destination register
- lu_wdata  in  WIDTH  long-latency result
- issue_valid  in  1  decode issues a long-latency op this cycle
- issue_wreg  in  5  destination of the issued op
- rreg1, rreg2  in  5  decode source registers
- hazard1, hazard2  out  1  source register is busy
- pipe_throttle  out  1  upstream must not present pipe_regwrite next cycle
- regwrite  out  1  to regfile write enable
- wreg  out  5  to regfile write address
- wdata  out  WIDTH  to regfile write data

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. On reset:
  - FIFO is emptied;
  - busy[] = 0, starve counter = 0;
  - regwrite = 0, wreg = 0, wdata = 0.
  - Combinational outputs after reset: lu_ready = 1, hazard1/2 = 0, pipe_throttle = 0.
  - Reset mid-operation discards queued results and busy state without writing them.
- FIFO:
  - lu_ready = !full, combinational from the FIFO count only.
  - Enqueue when lu_valid && lu_ready && lu_wreg != 0.
  - A result with lu_wreg == 0 is accepted (handshake completes) and discarded.
  - Pointers wrap modulo QDEPTH.
  - Count range is 0..QDEPTH. Enqueue and dequeue in the same cycle is legal when full; count is unchanged.
- Select, evaluated each cycle:
  - pipe_win = pipe_regwrite && pipe_wreg != 0.
  - If pipe_win: the pipeline result is selected.
  - Else, if the FIFO is non-empty: dequeue the head.
  - Else: nothing is selected.
- Output register, 1-cycle latency:
  - regwrite/wreg/wdata are registered from the selected source.
  - regwrite = 0 when nothing is selected; wreg/wdata then hold their previous values.
  - The regfile commits at the following edge.
- Starvation counter:
  - Increments when the FIFO is non-empty and pipe_win.
  - Clears on any dequeue or when the FIFO is empty.
  - Saturates at STARVE_MAX.
  - pipe_throttle = (count == STARVE_MAX).
  - If upstream violates throttle, the pipeline still wins and the counter holds.
- Scoreboard:
  - busy[issue_wreg] is set on issue_valid when issue_wreg != 0.
  - busy[wreg] is cleared at the edge where regwrite = 1 and the output register holds a long-latency entry (src_lu flag). This is the same edge the regfile writes, so no bypass is needed.
  - Set and clear of the same register in the same cycle: set wins (newer op).
  - busy[0] is always 0.
  - hazardN = busy[rregN], combinational.
- Protocol checks (simulation-only DMSG/error; no RTL effect):
  - issue_valid to an already-busy register;
  - pipe_win to a busy register (WAW).

Decomposition:
- Shared defines header:
  - register-address width (5);
  - zero-register index;
  - WIDTH default.
- One natural sub-module: wb_fifo, a parameterised synchronous FIFO (WIDTH+5 bits per entry, QDEPTH entries) with full/empty/count outputs. It is reusable for the store buffer.

Test Plan:
- Reset sequencing:
  - Stimulus: reset, then issue_valid wreg=5.
  - Required: hazard1 = 1 for rreg1 = 5 from the next cycle.
  - Stimulus: lu_valid wreg=5 data=0xDEADBEEF with no pipe traffic.
  - Required: regwrite = 1, wreg = 5, wdata = 0xDEADBEEF two cycles after acceptance; hazard1 drops at that same edge.
- Priority:
  - Stimulus: same cycle pipe_regwrite wreg=3 data=0x11 and lu_valid wreg=7 data=0x22.
  - Required: reg 3 written first, reg 7 on the next cycle.
- Backpressure:
  - Stimulus: continuous pipe writes; push 3 lu results.
  - Required: lu_ready = 0 after 2 entries. The third result is held by the source until a slot frees; no entry is lost or duplicated.
- Starvation:
  - Stimulus: FIFO non-empty plus STARVE_MAX = 4 consecutive pipe writes.
  - Required: pipe_throttle = 1 on cycle 4. With pipe idle the next cycle, the head is dequeued and the counter returns to 0.
- Register zero:
  - Stimulus: pipe wreg=0 while the FIFO holds wreg=9.
  - Required: reg 9 dequeues that cycle.
  - Stimulus: lu wreg=0.
  - Required: accepted, never written, busy unchanged.
- Set/clear collision:
  - Stimulus: issue_valid wreg=4 on the edge where the old reg-4 result commits.
  - Required: busy[4] remains 1.
